// File: rtl/rgbw_spi_byte_rx.sv
// SPI mode-0 slave byte receiver for the RGBW data dispenser.
// Pins are synchronised into clk, bytes are deserialised MSB first and
// presented with a stretched rdy strobe; the previous byte is echoed on miso.
module rgbw_spi_byte_rx #(
  parameter int unsigned RDY_HOLD    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic [7:0] buffRx_spi,
  output logic       rdy,
  output logic       overrun,
  output logic       frame_err
);

  localparam int unsigned HOLD_W = $clog2(RDY_HOLD + 1);
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_prev;
  logic                   cs_prev;

  logic sck_s;
  logic mosi_s;
  logic cs_s;
  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;

  logic [7:0]       shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       tx_reg;
  logic [HOLD_W-1:0] hold_cnt;

  logic [7:0]        shift_nxt;
  logic [CNT_W-1:0]  bit_cnt_nxt;
  logic [7:0]        tx_nxt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [7:0]        buff_nxt;
  logic              miso_nxt;
  logic              rdy_nxt;
  logic              overrun_nxt;
  logic              frame_err_nxt;
  logic              byte_done;

  // Pin synchronisers plus previous-value flops for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;

  assign byte_done = (state == SHIFT) && sck_rise && (bit_cnt == CNT_W'(7));

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: frame opens on cs_n fall, closes on cs_n rise
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: next values of the datapath and output registers
  always_comb begin
    shift_nxt     = shift_reg;
    bit_cnt_nxt   = bit_cnt;
    tx_nxt        = tx_reg;
    buff_nxt      = buffRx_spi;
    miso_nxt      = miso;
    overrun_nxt   = overrun;
    frame_err_nxt = 1'b0;
    hold_nxt      = (hold_cnt != '0) ? (hold_cnt - HOLD_W'(1)) : hold_cnt;

    case (state)
      IDLE: begin
        bit_cnt_nxt = '0;
        miso_nxt    = cs_fall ? tx_reg[7] : 1'b0;
      end
      SHIFT: begin
        if (sck_rise) begin
          shift_nxt   = {shift_reg[6:0], mosi_s};
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
        if (byte_done) begin
          buff_nxt    = {shift_reg[6:0], mosi_s};
          tx_nxt      = {shift_reg[6:0], mosi_s};
          bit_cnt_nxt = '0;
          hold_nxt    = HOLD_W'(RDY_HOLD);
          if (rdy) overrun_nxt = 1'b1;
        end
        // tx_reg stays intact so it survives across frames; bit index walks it
        if (sck_fall) miso_nxt = tx_reg[~bit_cnt];
        if (cs_rise) begin
          miso_nxt    = 1'b0;
          bit_cnt_nxt = '0;
          if (!byte_done && (bit_cnt != '0)) frame_err_nxt = 1'b1;
        end
      end
      default: begin
        bit_cnt_nxt = '0;
        miso_nxt    = 1'b0;
      end
    endcase

    rdy_nxt = (hold_nxt != '0);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      tx_reg     <= '0;
      hold_cnt   <= '0;
      buffRx_spi <= '0;
      miso       <= 1'b0;
      rdy        <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      shift_reg  <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      tx_reg     <= tx_nxt;
      hold_cnt   <= hold_nxt;
      buffRx_spi <= buff_nxt;
      miso       <= miso_nxt;
      rdy        <= rdy_nxt;
      overrun    <= overrun_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_rgbw_spi_byte_rx.sv
// Bench for rgbw_spi_byte_rx: two instances on shared pins, one with the
// default rdy hold and one with a long hold so back-to-back bytes overrun.
module tb_rgbw_spi_byte_rx;

  localparam int SYNC   = 2;
  localparam int HOLD_A = 4;
  localparam int HOLD_B = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic cs_n = 1'b1;

  logic       miso_a, rdy_a, ov_a, fe_a;
  logic       miso_b, rdy_b, ov_b, fe_b;
  logic [7:0] buf_a, buf_b;

  always #5 clk = ~clk;

  rgbw_spi_byte_rx #(.RDY_HOLD(HOLD_A), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .miso(miso_a), .buffRx_spi(buf_a), .rdy(rdy_a), .overrun(ov_a), .frame_err(fe_a)
  );

  rgbw_spi_byte_rx #(.RDY_HOLD(HOLD_B), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .miso(miso_b), .buffRx_spi(buf_b), .rdy(rdy_b), .overrun(ov_b), .frame_err(fe_b)
  );

  int total = 0;
  int bad = 0;

  // Edge bookkeeping: cyc = index of the last posedge, last_rst = last edge sampling reset
  int cyc = 0;
  int last_rst = 0;
  int cs_hi_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) last_rst <= cyc + 1;
    cs_hi_cnt <= cs_n ? cs_hi_cnt + 1 : 0;
  end

  // Model: timestamped events derived from what the bench drives
  int         comp_edge[$];
  logic [7:0] comp_byte[$];
  int         fe_edge[$];
  logic [7:0] tx_model = 8'h00;
  int         frame_bits = 0;
  int         last_k = 0;

  // Observations used by the literal checks
  bit         chk_on = 1'b0;
  int         rdy_hi_a = 0;
  int         rises_a = 0;
  int         rise_edge_a = 0;
  int         fe_cnt_a = 0;
  logic       rdy_a_prev = 1'b0;
  logic [7:0] got_bytes[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs after edge n for an instance with the given hold length
  function automatic void model_out(input int hold, input int n,
                                    output logic [7:0] b, output logic r, output logic o);
    int prev;
    prev = -1;
    b = 8'h00;
    r = 1'b0;
    o = 1'b0;
    foreach (comp_edge[i]) begin
      if (comp_edge[i] > last_rst && comp_edge[i] <= n) begin
        if (prev >= 0 && comp_edge[i] - prev <= hold) o = 1'b1;
        b = comp_byte[i];
        if (n < comp_edge[i] + hold) r = 1'b1;
        prev = comp_edge[i];
      end
    end
  endfunction

  function automatic logic model_fe(input int n);
    logic f;
    f = 1'b0;
    foreach (fe_edge[i]) if (fe_edge[i] == n && fe_edge[i] > last_rst) f = 1'b1;
    return f;
  endfunction

  // Compare both instances against the model once per cycle, mid-period
  always @(negedge clk) begin
    if (chk_on) begin
      logic [7:0] eb;
      logic er, eo, ef;
      ef = model_fe(cyc);
      model_out(HOLD_A, cyc, eb, er, eo);
      chk("a_buff", 32'(buf_a), 32'(eb));
      chk("a_rdy", 32'(rdy_a), 32'(er));
      chk("a_overrun", 32'(ov_a), 32'(eo));
      chk("a_frame_err", 32'(fe_a), 32'(ef));
      model_out(HOLD_B, cyc, eb, er, eo);
      chk("b_buff", 32'(buf_b), 32'(eb));
      chk("b_rdy", 32'(rdy_b), 32'(er));
      chk("b_overrun", 32'(ov_b), 32'(eo));
      chk("b_frame_err", 32'(fe_b), 32'(ef));
      if (cs_hi_cnt >= SYNC + 1) begin
        chk("a_miso_idle", 32'(miso_a), 32'd0);
        chk("b_miso_idle", 32'(miso_b), 32'd0);
      end
      rdy_hi_a += int'(rdy_a);
      fe_cnt_a += int'(fe_a);
      if (rdy_a && !rdy_a_prev) begin
        rises_a++;
        rise_edge_a = cyc;
        got_bytes.push_back(buf_a);
      end
      rdy_a_prev = rdy_a;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_begin(input int ph);
    cs_n = 1'b0;
    frame_bits = 0;
    tick(ph);
  endtask

  // Master side: mosi moves one clk before each sck rise; miso sampled at the rise
  task automatic send_bits(input logic [7:0] b, input int nbits, input int ph);
    for (int i = 0; i < nbits; i++) begin
      tick(ph - 1);
      mosi = b[7 - i];
      tick(1);
      chk("a_miso_bit", 32'(miso_a), 32'(tx_model[7 - frame_bits]));
      chk("b_miso_bit", 32'(miso_b), 32'(tx_model[7 - frame_bits]));
      sck = 1'b1;
      last_k = cyc + 1;
      frame_bits++;
      if (frame_bits == 8) begin
        comp_edge.push_back(last_k + SYNC);
        comp_byte.push_back(b);
        tx_model = b;
        frame_bits = 0;
      end
      tick(ph);
      sck = 1'b0;
    end
  endtask

  task automatic frame_end(input int ph);
    tick(ph);
    cs_n = 1'b1;
    if (frame_bits != 0) fe_edge.push_back(cyc + 1 + SYNC);
    frame_bits = 0;
    tick(ph);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    cs_n = 1'b1;
    frame_bits = 0;
    tx_model = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(4);
  endtask

  logic [7:0] seq2 [8] = '{8'h55, 8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'h01};

  initial begin
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("rst_buff", 32'(buf_a), 32'h00);
    chk("rst_rdy", 32'(rdy_a), 32'd0);
    chk("rst_miso", 32'(miso_a), 32'd0);

    // Single byte at sck period 8 clk
    rdy_hi_a = 0;
    frame_begin(4);
    send_bits(8'h55, 8, 4);
    frame_end(4);
    tick(8);
    chk("t1_buff", 32'(buf_a), 32'h55);
    chk("t1_rdy_width", 32'(rdy_hi_a), 32'd4);
    chk("t1_overrun", 32'(ov_a), 32'd0);

    // Eight-byte frame
    rises_a = 0;
    got_bytes.delete();
    frame_begin(4);
    foreach (seq2[i]) send_bits(seq2[i], 8, 4);
    frame_end(4);
    tick(8);
    chk("t2_rdy_pulses", 32'(rises_a), 32'd8);
    chk("t2_nbytes", 32'(got_bytes.size()), 32'd8);
    foreach (got_bytes[i]) if (i < 8) chk("t2_byte", 32'(got_bytes[i]), 32'(seq2[i]));

    // Truncated frame, then a good byte
    fe_cnt_a = 0;
    frame_begin(4);
    send_bits(8'hF0, 5, 4);
    frame_end(4);
    tick(8);
    chk("t3_fe_pulses", 32'(fe_cnt_a), 32'd1);
    chk("t3_buff_kept", 32'(buf_a), 32'h01);
    chk("t3_rdy", 32'(rdy_a), 32'd0);
    frame_begin(4);
    send_bits(8'h3C, 8, 4);
    frame_end(4);
    tick(8);
    chk("t3_buff", 32'(buf_a), 32'h3C);

    // Back-to-back bytes at fastest legal sck: long-hold instance overruns
    frame_begin(3);
    send_bits(8'h12, 8, 3);
    send_bits(8'h34, 8, 3);
    frame_end(3);
    tick(8);
    chk("t4_buff_b", 32'(buf_b), 32'h34);
    chk("t4_overrun_b", 32'(ov_b), 32'd1);
    chk("t4_overrun_a", 32'(ov_a), 32'd0);
    tick(100);
    chk("t4_overrun_sticky", 32'(ov_b), 32'd1);

    // Reset in the middle of a byte
    fe_cnt_a = 0;
    frame_begin(4);
    send_bits(8'hA5, 4, 4);
    do_reset();
    chk("t5_no_fe", 32'(fe_cnt_a), 32'd0);
    chk("t5_overrun_cleared", 32'(ov_b), 32'd0);
    frame_begin(4);
    send_bits(8'hA5, 8, 4);
    frame_end(4);
    tick(8);
    chk("t5_buff", 32'(buf_a), 32'hA5);

    // Minimum phases, latency from pin sampling to output
    frame_begin(3);
    send_bits(8'hC3, 8, 3);
    frame_end(3);
    tick(8);
    chk("t6_buff", 32'(buf_a), 32'hC3);
    chk("t6_latency", 32'(rise_edge_a - last_k), 32'd2);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1);
  end

endmodule
